// File: rtl/arb_burst_ctrl.sv
// Burst owner latch + fixed-length beat mover from one granted requester to a shared channel.
// Latency: one cycle from source accept to m_valid; grant to first src_ready is one cycle.
// Backpressure: src_ready follows the m_ready pop of the output register; stalled owners abort after TIMEOUT cycles.
module arb_burst_ctrl #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      gnt_i,
    input  logic [3:0]      src_valid,
    input  logic [4*DW-1:0] src_data,
    output logic [3:0]      src_ready,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    input  logic            m_ready,
    output logic [1:0]      m_owner,
    output logic            busy,
    output logic [3:0]      done,
    output logic            abort,
    output logic            gnt_err
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LP_BURST      = BW'(BURST_LEN);
    localparam logic [BW-1:0] LP_BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [TW-1:0] LP_TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_owner;
    logic [BW-1:0]   r_beat_cnt;
    logic [TW-1:0]   r_stall_cnt;
    logic            r_m_valid;
    logic [DW-1:0]   r_m_data;
    logic            r_aborted;
    logic            r_gnt_err;

    logic            w_gnt_onehot;
    logic [1:0]      w_gnt_idx;
    logic [DW-1:0]   w_beat;
    logic            w_src_rdy_own;
    logic            w_accept;
    logic            w_stall;
    logic            w_abort;
    logic            w_drain_exit;

    assign w_gnt_onehot = (gnt_i != 4'd0) && ((gnt_i & (gnt_i - 4'd1)) == 4'd0);

    always_comb begin
        w_gnt_idx = 2'd0;
        if (gnt_i[1]) w_gnt_idx = 2'd1;
        if (gnt_i[2]) w_gnt_idx = 2'd2;
        if (gnt_i[3]) w_gnt_idx = 2'd3;
    end

    assign w_beat = src_data[DW*32'(r_owner) +: DW];

    always_comb begin
        w_state_nxt   = r_state;
        w_src_rdy_own = 1'b0;
        w_accept      = 1'b0;
        w_stall       = 1'b0;
        w_abort       = 1'b0;
        w_drain_exit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_onehot) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                w_src_rdy_own = (!r_m_valid || m_ready) && (r_beat_cnt < LP_BURST);
                w_accept      = w_src_rdy_own && src_valid[r_owner];
                w_stall       = w_src_rdy_own && !src_valid[r_owner];
                if (w_accept && (r_beat_cnt == LP_BURST_LAST)) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_stall && (r_stall_cnt == LP_TO_LAST)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Exit in the same cycle the last beat pops (or at once if already empty).
                if (!r_m_valid || m_ready) begin
                    w_drain_exit = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= 2'd0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_aborted   <= 1'b0;
            r_gnt_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_err <= (r_state == S_IDLE) && (gnt_i != 4'd0) && !w_gnt_onehot;

            if ((r_state == S_IDLE) && w_gnt_onehot) begin
                r_owner     <= w_gnt_idx;
                r_beat_cnt  <= '0;
                r_stall_cnt <= '0;
                r_aborted   <= 1'b0;
            end

            if (w_accept) begin
                r_beat_cnt  <= r_beat_cnt + 1'b1;
                r_stall_cnt <= '0;
            end else if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (w_abort) r_aborted <= 1'b1;

            // A new beat replaces a popped one without a bubble.
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_beat;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign src_ready = w_src_rdy_own ? (4'b0001 << r_owner) : 4'b0000;
    assign done      = (w_drain_exit && !r_aborted) ? (4'b0001 << r_owner) : 4'b0000;
    assign abort     = w_abort;
    assign gnt_err   = r_gnt_err;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_owner   = r_owner;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_arb_burst_ctrl.sv
// Directed bench for arb_burst_ctrl: per-cycle vector table plus hand sequences
// for timeout abort and asynchronous reset mid-burst.
module tb_arb_burst_ctrl;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      gnt_i = 4'd0;
    logic [3:0]      src_valid = 4'd0;
    logic [4*DW-1:0] src_data = '0;
    logic [3:0]      src_ready;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_ready = 1'b0;
    logic [1:0]      m_owner;
    logic            busy;
    logic [3:0]      done;
    logic            abort;
    logic            gnt_err;

    arb_burst_ctrl #(.DW(DW), .BURST_LEN(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .gnt_i(gnt_i), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .m_owner(m_owner), .busy(busy),
        .done(done), .abort(abort), .gnt_err(gnt_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] base [4];
    int idx [4];

    typedef struct {
        string      name;
        bit         rst_idx;
        logic [3:0] gnt;
        logic [3:0] sv;
        logic       mr;
        logic       mv;
        logic [7:0] md;
        logic [3:0] sr;
        logic       busy;
        logic [3:0] done;
        logic [1:0] owner;
        logic       abort;
        logic       gerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, bit ri, logic [3:0] g, logic [3:0] sv, logic mr,
                                logic mv, logic [7:0] md, logic [3:0] sr, logic b,
                                logic [3:0] d, logic [1:0] o, logic ab, logic ge);
        vec_t v;
        v.name = n; v.rst_idx = ri; v.gnt = g; v.sv = sv; v.mr = mr; v.mv = mv;
        v.md = md; v.sr = sr; v.busy = b; v.done = d; v.owner = o; v.abort = ab; v.gerr = ge;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        if (v.rst_idx) for (int k = 0; k < 4; k++) idx[k] = 0;
        gnt_i     = v.gnt;
        src_valid = v.sv;
        m_ready   = v.mr;
        for (int k = 0; k < 4; k++) src_data[k*DW +: DW] = base[k] + 8'(idx[k]);
        #1;
        chk({v.name, ".m_valid"}, 32'(m_valid), 32'(v.mv));
        if (v.mv) chk({v.name, ".m_data"}, 32'(m_data), 32'(v.md));
        chk({v.name, ".src_ready"}, 32'(src_ready), 32'(v.sr));
        chk({v.name, ".busy"}, 32'(busy), 32'(v.busy));
        chk({v.name, ".done"}, 32'(done), 32'(v.done));
        chk({v.name, ".m_owner"}, 32'(m_owner), 32'(v.owner));
        chk({v.name, ".abort"}, 32'(abort), 32'(v.abort));
        chk({v.name, ".gnt_err"}, 32'(gnt_err), 32'(v.gerr));
    endtask

    task automatic step();
        for (int k = 0; k < 4; k++) if (src_ready[k] && src_valid[k]) idx[k]++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(vec_t v);
        apply(v);
        step();
    endtask

    initial begin
        base[0] = 8'h21; base[1] = 8'h51; base[2] = 8'h11; base[3] = 8'h41;
        for (int k = 0; k < 4; k++) idx[k] = 0;

        // Test 1: owner 2 full burst, then same requester re-granted across the idle gap.
        tbl.push_back(mk("t1c0", 1, 4'b0100, 4'b0100, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk("t1c1", 0, 4'b0000, 4'b0100, 1, 0, 8'h00, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t1c2", 0, 4'b0000, 4'b0100, 1, 1, 8'h11, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t1c3", 0, 4'b0000, 4'b0100, 1, 1, 8'h12, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t1c4", 0, 4'b0000, 4'b0100, 1, 1, 8'h13, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t1c5", 0, 4'b0100, 4'b0100, 1, 1, 8'h14, 4'b0000, 1, 4'b0100, 2'd2, 0, 0));
        tbl.push_back(mk("t1c6", 1, 4'b0100, 4'b0100, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd2, 0, 0));
        // Test 2: m_ready low for 5 cycles mid-burst.
        tbl.push_back(mk("t2c1", 0, 4'b0000, 4'b0100, 1, 0, 8'h00, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t2c2", 0, 4'b0000, 4'b0100, 1, 1, 8'h11, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("t2hold", 0, 4'b0000, 4'b0100, 0, 1, 8'h12, 4'b0000, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t2c8", 0, 4'b0000, 4'b0100, 1, 1, 8'h12, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t2c9", 0, 4'b0000, 4'b0100, 1, 1, 8'h13, 4'b0100, 1, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t2c10", 0, 4'b0000, 4'b0100, 1, 1, 8'h14, 4'b0000, 1, 4'b0100, 2'd2, 0, 0));
        tbl.push_back(mk("t2c11", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd2, 0, 0));
        // Test 3: grant moves to requester 3 during owner 0's burst.
        tbl.push_back(mk("t3c0", 1, 4'b0001, 4'b1001, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd2, 0, 0));
        tbl.push_back(mk("t3c1", 0, 4'b1000, 4'b1001, 1, 0, 8'h00, 4'b0001, 1, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk("t3c2", 0, 4'b1000, 4'b1001, 1, 1, 8'h21, 4'b0001, 1, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk("t3c3", 0, 4'b1000, 4'b1001, 1, 1, 8'h22, 4'b0001, 1, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk("t3c4", 0, 4'b1000, 4'b1001, 1, 1, 8'h23, 4'b0001, 1, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk("t3c5", 0, 4'b1000, 4'b1001, 1, 1, 8'h24, 4'b0000, 1, 4'b0001, 2'd0, 0, 0));
        tbl.push_back(mk("t3c6", 0, 4'b1000, 4'b1001, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd0, 0, 0));
        tbl.push_back(mk("t3c7", 0, 4'b0000, 4'b1001, 1, 0, 8'h00, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        tbl.push_back(mk("t3c8", 0, 4'b0000, 4'b1001, 1, 1, 8'h41, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        tbl.push_back(mk("t3c9", 0, 4'b0000, 4'b1001, 1, 1, 8'h42, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        tbl.push_back(mk("t3c10", 0, 4'b0000, 4'b1001, 1, 1, 8'h43, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        tbl.push_back(mk("t3c11", 0, 4'b0000, 4'b1001, 1, 1, 8'h44, 4'b0000, 1, 4'b1000, 2'd3, 0, 0));
        tbl.push_back(mk("t3c12", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd3, 0, 0));
        // Test 5: non-one-hot grant in IDLE.
        tbl.push_back(mk("t5c0", 0, 4'b0110, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd3, 0, 0));
        tbl.push_back(mk("t5c1", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd3, 0, 1));
        tbl.push_back(mk("t5c2", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd3, 0, 0));

        // Reset state, sampled while rst_n is low.
        #1;
        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.m_data", 32'(m_data), 32'd0);
        chk("rst.src_ready", 32'(src_ready), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.m_owner", 32'(m_owner), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.abort", 32'(abort), 32'd0);
        chk("rst.gnt_err", 32'(gnt_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i]);

        // Test 4: owner 1 stops after two beats; timeout abort, no done.
        run(mk("t4c0", 1, 4'b0010, 4'b0010, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd3, 0, 0));
        run(mk("t4c1", 0, 4'b0000, 4'b0010, 1, 0, 8'h00, 4'b0010, 1, 4'b0000, 2'd1, 0, 0));
        run(mk("t4c2", 0, 4'b0000, 4'b0010, 1, 1, 8'h51, 4'b0010, 1, 4'b0000, 2'd1, 0, 0));
        run(mk("t4c3", 0, 4'b0000, 4'b0000, 1, 1, 8'h52, 4'b0010, 1, 4'b0000, 2'd1, 0, 0));
        for (int i = 4; i < 18; i++)
            run(mk("t4stall", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0010, 1, 4'b0000, 2'd1, 0, 0));
        run(mk("t4abort", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0010, 1, 4'b0000, 2'd1, 1, 0));
        run(mk("t4drain", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 1, 4'b0000, 2'd1, 0, 0));
        run(mk("t4idle", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd1, 0, 0));

        // Test 6: asynchronous reset while a beat sits on the output.
        run(mk("t6c0", 1, 4'b0001, 4'b0001, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd1, 0, 0));
        run(mk("t6c1", 0, 4'b0000, 4'b0001, 0, 0, 8'h00, 4'b0001, 1, 4'b0000, 2'd0, 0, 0));
        apply(mk("t6c2", 0, 4'b0000, 4'b0001, 0, 1, 8'h21, 4'b0000, 1, 4'b0000, 2'd0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6rst.m_valid", 32'(m_valid), 32'd0);
        chk("t6rst.m_data", 32'(m_data), 32'd0);
        chk("t6rst.src_ready", 32'(src_ready), 32'd0);
        chk("t6rst.busy", 32'(busy), 32'd0);
        chk("t6rst.done", 32'(done), 32'd0);
        chk("t6rst.abort", 32'(abort), 32'd0);
        chk("t6rst.m_owner", 32'(m_owner), 32'd0);
        step();
        rst_n = 1'b1;
        run(mk("t6n0", 1, 4'b1000, 4'b1000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd0, 0, 0));
        run(mk("t6n1", 0, 4'b0000, 4'b1000, 1, 0, 8'h00, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        run(mk("t6n2", 0, 4'b0000, 4'b1000, 1, 1, 8'h41, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        run(mk("t6n3", 0, 4'b0000, 4'b1000, 1, 1, 8'h42, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        run(mk("t6n4", 0, 4'b0000, 4'b1000, 1, 1, 8'h43, 4'b1000, 1, 4'b0000, 2'd3, 0, 0));
        run(mk("t6n5", 0, 4'b0000, 4'b1000, 1, 1, 8'h44, 4'b0000, 1, 4'b1000, 2'd3, 0, 0));
        run(mk("t6n6", 0, 4'b0000, 4'b0000, 1, 0, 8'h00, 4'b0000, 0, 4'b0000, 2'd3, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
